// File: rtl/command_executor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : command_executor_pkg                                         |
// | Description : Shared types for the command executor: command and status   |
// |               encodings, FSM state type, and the saturating increment used |
// |               for the error counter.                                       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package command_executor_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } command_t;

  typedef enum logic {
    OK    = 1'b0,
    ERROR = 1'b1
  } status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int              ERROR_COUNT_WIDTH = 8;
  localparam logic [ERROR_COUNT_WIDTH-1:0] ERROR_COUNT_MAX = '1;

  // Counter sticks at its maximum instead of wrapping back to zero.
  function automatic logic [ERROR_COUNT_WIDTH-1:0] sat_inc(
    input logic [ERROR_COUNT_WIDTH-1:0] value
  );
    if (value == ERROR_COUNT_MAX) begin
      return value;
    end
    return value + {{(ERROR_COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/command_executor_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : command_executor_regfile                                     |
// | Description : DEPTH x DATA_WIDTH register array with synchronous           |
// |               active-low clear, one enabled write port and one             |
// |               combinational read port. Addresses outside the array read    |
// |               as zero and never write; range policy lives in the parent.   |
// | Ports       : i_clk    - clock                                             |
// |               i_rst    - synchronous clear, active low                     |
// |               i_we     - write enable                                      |
// |               i_waddr  - write address                                     |
// |               i_wdata  - write data                                        |
// |               i_raddr  - read address                                      |
// |               o_rdata  - read data (combinational)                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module command_executor_regfile
  import command_executor_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      // Decode per entry so an out-of-array address simply matches nothing.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_waddr == ADDR_WIDTH'(i)) begin
          r_mem[i] <= i_wdata;
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == ADDR_WIDTH'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/command_executor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : command_executor                                             |
// | Description : Command/status bus slave endpoint. Accepts one WRITE or READ |
// |               at a time, executes it against an internal register array    |
// |               after LATENCY cycles and returns OK/ERROR plus read data.    |
// | Ports       : i_clk           - clock                                      |
// |               i_rst           - synchronous reset, active low              |
// |               i_command_valid - command offered                            |
// |               o_command_ready - executor can accept a command              |
// |               i_command       - WRITE or READ                              |
// |               i_addr          - target entry                               |
// |               i_wdata         - write data (ignored for READ)              |
// |               o_status_valid  - response offered                           |
// |               i_status_ready  - consumer accepts the response              |
// |               o_status        - OK or ERROR                                |
// |               o_rdata         - read data, 0 for WRITE and ERROR           |
// |               o_error_count   - saturating count of ERROR responses        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module command_executor
  import command_executor_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int LATENCY    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_command_valid,
  output logic                         o_command_ready,
  input  command_t                     i_command,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic                         o_status_valid,
  input  logic                         i_status_ready,
  output status_t                      o_status,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic [ERROR_COUNT_WIDTH-1:0] o_error_count
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  command_t                       r_cmd;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic                           r_command_ready;
  logic                           r_status_valid;
  status_t                        r_status;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [ERROR_COUNT_WIDTH-1:0]   r_error_count;

  logic                           w_in_range;
  logic                           w_resolve;
  logic                           w_we;
  logic [DATA_WIDTH-1:0]          w_rd_data;

  // Full-width compare: addresses past DEPTH never alias onto real entries.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_EXT);
  assign w_resolve  = (r_state == EXEC) && (r_cnt == '0);
  // Storage changes only in the resolve cycle, so a later READ sees every
  // completed WRITE.
  assign w_we       = w_resolve && w_in_range && (r_cmd == WRITE);

  command_executor_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_cmd           <= WRITE;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_command_ready <= 1'b1;
      r_status_valid  <= 1'b0;
      r_status        <= OK;
      r_rdata         <= '0;
      r_error_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Ready is always high here, so valid alone completes the handshake.
          if (i_command_valid) begin
            r_cmd           <= i_command;
            r_addr          <= i_addr;
            r_wdata         <= i_wdata;
            r_cnt           <= CNT_W'(LATENCY - 1);
            r_command_ready <= 1'b0;
            r_state         <= EXEC;
          end
        end

        EXEC: begin
          if (r_cnt == '0) begin
            if (!w_in_range) begin
              r_status      <= ERROR;
              r_rdata       <= '0;
              r_error_count <= sat_inc(r_error_count);
            end else if (r_cmd == READ) begin
              r_status <= OK;
              r_rdata  <= w_rd_data;
            end else begin
              r_status <= OK;
              r_rdata  <= '0;
            end
            r_status_valid <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          // Status and data hold their values until the consumer takes them.
          if (i_status_ready) begin
            r_status_valid  <= 1'b0;
            r_command_ready <= 1'b1;
            r_state         <= IDLE;
          end
        end

        default: begin
          r_status_valid  <= 1'b0;
          r_command_ready <= 1'b1;
          r_state         <= IDLE;
        end
      endcase
    end
  end

  assign o_command_ready = r_command_ready;
  assign o_status_valid  = r_status_valid;
  assign o_status        = r_status;
  assign o_rdata         = r_rdata;
  assign o_error_count   = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_command_executor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_command_executor                                          |
// | Description : Self-checking bench for command_executor: directed table,    |
// |               randomized transactions against a behavioural model, and     |
// |               hand sequences for backpressure, reset and saturation.       |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_command_executor;
  import command_executor_pkg::*;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 12;
  localparam int LATENCY    = 2;

  logic                  clk;
  logic                  rst;
  logic                  command_valid;
  logic                  command_ready;
  command_t              command;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  status_valid;
  logic                  status_ready;
  status_t               status;
  logic [DATA_WIDTH-1:0] rdata;
  logic [7:0]            error_count;

  command_executor #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_command_valid (command_valid),
    .o_command_ready (command_ready),
    .i_command       (command),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .o_status_valid  (status_valid),
    .i_status_ready  (status_ready),
    .o_status        (status),
    .o_rdata         (rdata),
    .o_error_count   (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: plain array of entries plus an integer error tally.
  logic [7:0] m_mem [16];
  int         m_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_err = 0;
  endtask

  task automatic model_exec(input command_t c, input int a, input logic [7:0] d,
                            output status_t s, output logic [7:0] r);
    if (a >= DEPTH) begin
      s = ERROR;
      r = 8'h00;
      m_err = (m_err >= 255) ? 255 : m_err + 1;
    end else if (c == WRITE) begin
      m_mem[a] = d;
      s = OK;
      r = 8'h00;
    end else begin
      s = OK;
      r = m_mem[a];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer, accept, check EXEC quiet period, check the
  // response (held through bp cycles of backpressure), then handshake.
  // With offer set, a follow-on command is presented during RESP and left
  // asserted on exit.
  task automatic do_cmd(input command_t c, input logic [3:0] a, input logic [7:0] d,
                        input int bp, input status_t es, input logic [7:0] er,
                        input logic [7:0] ee, input bit offer, input command_t oc,
                        input logic [3:0] oa, input logic [7:0] od);
    int w;
    command       = c;
    addr          = a;
    wdata         = d;
    command_valid = 1'b1;
    status_ready  = 1'b0;
    w = 0;
    while (!command_ready && w < 20) begin
      step();
      w++;
    end
    if (!command_ready) begin
      chk("accept_timeout", 32'(command_ready), 32'd1);
      command_valid = 1'b0;
      return;
    end
    step();
    command_valid = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      // Scramble the command fields; the response must ignore them.
      command      = command_t'($urandom_range(0, 1));
      addr         = 4'($urandom);
      wdata        = 8'($urandom);
      status_ready = 1'($urandom_range(0, 1));
      chk("exec_ready_low", 32'(command_ready), 32'd0);
      chk("exec_valid_low", 32'(status_valid), 32'd0);
      step();
    end
    status_ready = 1'b0;
    if (offer) begin
      command       = oc;
      addr          = oa;
      wdata         = od;
      command_valid = 1'b1;
    end
    for (int k = 0; k < bp; k++) begin
      chk("bp_valid",  32'(status_valid), 32'd1);
      chk("bp_status", 32'(status), 32'(es));
      chk("bp_rdata",  32'(rdata), 32'(er));
      chk("bp_ready",  32'(command_ready), 32'd0);
      step();
    end
    chk("resp_valid",  32'(status_valid), 32'd1);
    chk("resp_status", 32'(status), 32'(es));
    chk("resp_rdata",  32'(rdata), 32'(er));
    chk("resp_errcnt", 32'(error_count), 32'(ee));
    chk("resp_ready",  32'(command_ready), 32'd0);
    status_ready = 1'b1;
    step();
    status_ready = 1'b0;
    chk("post_valid", 32'(status_valid), 32'd0);
    chk("post_ready", 32'(command_ready), 32'd1);
  endtask

  // Model-driven transaction without a follow-on offer.
  task automatic model_cmd(input command_t c, input logic [3:0] a,
                           input logic [7:0] d, input int bp);
    status_t    s;
    logic [7:0] r;
    model_exec(c, int'(a), d, s, r);
    do_cmd(c, a, d, bp, s, r, 8'(m_err), 1'b0, WRITE, 4'd0, 8'd0);
  endtask

  typedef struct {
    command_t   cmd;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         bp;
    status_t    st;
    logic [7:0] rd;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl [11];

  initial begin
    status_t    s;
    logic [7:0] r;

    tbl[0]  = '{WRITE, 4'd3,  8'hA5, 0, OK,    8'h00, 8'd0};
    tbl[1]  = '{READ,  4'd3,  8'h00, 0, OK,    8'hA5, 8'd0};
    tbl[2]  = '{READ,  4'd4,  8'h00, 0, OK,    8'h00, 8'd0};
    tbl[3]  = '{WRITE, 4'd13, 8'hFF, 0, ERROR, 8'h00, 8'd1};
    tbl[4]  = '{READ,  4'd13, 8'h00, 0, ERROR, 8'h00, 8'd2};
    tbl[5]  = '{WRITE, 4'd11, 8'h5A, 5, OK,    8'h00, 8'd2};
    tbl[6]  = '{READ,  4'd11, 8'h00, 2, OK,    8'h5A, 8'd2};
    tbl[7]  = '{READ,  4'd12, 8'h00, 0, ERROR, 8'h00, 8'd3};
    tbl[8]  = '{WRITE, 4'd0,  8'h01, 1, OK,    8'h00, 8'd3};
    tbl[9]  = '{READ,  4'd0,  8'h00, 0, OK,    8'h01, 8'd3};
    tbl[10] = '{READ,  4'd15, 8'h00, 0, ERROR, 8'h00, 8'd4};

    rst           = 1'b0;
    command_valid = 1'b0;
    command       = WRITE;
    addr          = '0;
    wdata         = '0;
    status_ready  = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    step();

    chk("rst_ready",  32'(command_ready), 32'd1);
    chk("rst_valid",  32'(status_valid), 32'd0);
    chk("rst_status", 32'(status), 32'(OK));
    chk("rst_rdata",  32'(rdata), 32'd0);
    chk("rst_errcnt", 32'(error_count), 32'd0);

    // Directed table; the model tracks state so later phases stay consistent.
    for (int i = 0; i < 11; i++) begin
      model_exec(tbl[i].cmd, int'(tbl[i].addr), tbl[i].wdata, s, r);
      do_cmd(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].bp,
             tbl[i].st, tbl[i].rd, tbl[i].ec, 1'b0, WRITE, 4'd0, 8'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      model_cmd(command_t'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                8'($urandom), int'($urandom_range(0, 3)));
    end

    // A command offered during backpressure waits for the status handshake.
    model_exec(WRITE, 5, 8'h77, s, r);
    do_cmd(WRITE, 4'd5, 8'h77, 5, s, r, 8'(m_err), 1'b1, READ, 4'd5, 8'h00);
    model_cmd(READ, 4'd5, 8'h00, 0);

    // Reset in the middle of EXEC for a WRITE: nothing is stored or reported.
    command       = WRITE;
    addr          = 4'd2;
    wdata         = 8'h3C;
    command_valid = 1'b1;
    chk("pre_rst_ready", 32'(command_ready), 32'd1);
    step();
    command_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    chk("midrst_ready",  32'(command_ready), 32'd1);
    chk("midrst_valid",  32'(status_valid), 32'd0);
    chk("midrst_status", 32'(status), 32'(OK));
    chk("midrst_rdata",  32'(rdata), 32'd0);
    chk("midrst_errcnt", 32'(error_count), 32'd0);
    model_cmd(READ, 4'd2, 8'h00, 0);

    // Push the error counter past its ceiling.
    for (int i = 0; i < 258; i++) begin
      model_cmd(command_t'($urandom_range(0, 1)), 4'($urandom_range(12, 15)),
                8'($urandom), 0);
    end
    chk("sat_errcnt", 32'(error_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
